conv_relu_pool: RTL and testbench

Post-processing stage directly downstream of `matrix_convolution`. It captures one 4x4 signed 16-bit convolution result tile and applies bias add, ReLU, rounding right-shift and int8 saturation. It then performs 2x2 max-pooling and streams the four pooled int8 values out over a valid/ready handshake. Its `start` is driven by the convolution stage's `done` pulse.

---
 rtl/conv_relu_pool.sv | 176 +++++++++++++++++
 tb/tb_conv_relu_pool.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_pool.sv
// Post-convolution stage: bias + ReLU + rounding shift + int8 saturation,
// then 2x2 max-pool of the 4x4 tile, streamed out over valid/ready.
module conv_relu_pool (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] c_in [0:3][0:3],
  input  logic signed [15:0] bias,
  input  logic        [3:0]  shift,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data,
  output logic        [1:0]  out_idx,
  output logic               done
);

  localparam int unsigned CW = 16;
  localparam int unsigned QW = 8;
  localparam int unsigned NE = 16;
  localparam int unsigned NP = 4;

  typedef enum logic [1:0] {IDLE, QUANT, POOL, OUT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [CW-1:0]   c_q [NE];
  logic [CW-1:0]   c_d [NE];
  logic [CW-1:0]   bias_q, bias_d;
  logic [3:0]      shift_q, shift_d;
  logic [QW-1:0]   q_q [NE];
  logic [QW-1:0]   q_d [NE];
  logic [QW-1:0]   p_q [NP];
  logic [QW-1:0]   p_d [NP];
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [QW-1:0]   out_data_q, out_data_d;
  logic [1:0]      out_idx_q, out_idx_d;
  logic            done_q, done_d;

  logic [CW:0]     sum_c;
  logic [17:0]     relu_c;
  logic [17:0]     round_c;
  logic [QW-1:0]   quant_c;
  logic [3:0]      base_c;
  logic [QW-1:0]   top_c;
  logic [QW-1:0]   bot_c;
  logic [QW-1:0]   pool_c;

  // Quantise element k: 17-bit bias add, ReLU, round-half-up shift, clamp to 127
  always_comb begin
    sum_c   = {c_q[k_q][CW-1], c_q[k_q]} + {bias_q[CW-1], bias_q};
    relu_c  = sum_c[CW] ? 18'd0 : {1'b0, sum_c};
    round_c = relu_c;
    if (shift_q != 4'd0) begin
      round_c = (relu_c + (18'd1 << (shift_q - 4'd1))) >> shift_q;
    end
    quant_c = (round_c > 18'd127) ? QW'(127) : round_c[QW-1:0];
  end

  // Max of the 2x2 window selected by k[1:0]; quantised values are non-negative
  always_comb begin
    base_c = {k_q[1], 1'b0, k_q[0], 1'b0};
    top_c  = (q_q[base_c] > q_q[4'(base_c + 4'd1)]) ? q_q[base_c] : q_q[4'(base_c + 4'd1)];
    bot_c  = (q_q[4'(base_c + 4'd4)] > q_q[4'(base_c + 4'd5)]) ?
             q_q[4'(base_c + 4'd4)] : q_q[4'(base_c + 4'd5)];
    pool_c = (top_c > bot_c) ? top_c : bot_c;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    c_d         = c_q;
    bias_d      = bias_q;
    shift_d     = shift_q;
    q_d         = q_q;
    p_d         = p_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
              c_d[r*4 + c] = c_in[r][c];
            end
          end
          bias_d  = bias;
          shift_d = shift;
          k_d     = 4'd0;
          busy_d  = 1'b1;
          state_d = QUANT;
        end
      end
      QUANT: begin
        q_d[k_q] = quant_c;
        k_d      = 4'(k_q + 4'd1);
        if (k_q == 4'd15) begin
          state_d = POOL;
        end
      end
      POOL: begin
        p_d[k_q[1:0]] = pool_c;
        k_d           = 4'(k_q + 4'd1);
        if (k_q[1:0] == 2'd3) begin
          // Window 0 was pooled three cycles ago, so it is ready to present now
          out_valid_d = 1'b1;
          out_idx_d   = 2'd0;
          out_data_d  = p_q[0];
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          if (out_idx_q == 2'd3) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            out_idx_d  = 2'(out_idx_q + 2'd1);
            out_data_d = p_q[2'(out_idx_q + 2'd1)];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      bias_q      <= '0;
      shift_q     <= 4'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 2'd0;
      done_q      <= 1'b0;
      for (int i = 0; i < NE; i++) begin
        c_q[i] <= '0;
        q_q[i] <= '0;
      end
      for (int i = 0; i < NP; i++) begin
        p_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      bias_q      <= bias_d;
      shift_q     <= shift_d;
      q_q         <= q_d;
      p_q         <= p_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_relu_pool.sv
// Bench for conv_relu_pool: directed tiles plus random tiles against an
// arithmetic reference of the quantise/pool rules.
module tb_conv_relu_pool;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [15:0] c_in [0:3][0:3];
  logic signed [15:0] bias;
  logic        [3:0]  shift;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic        [1:0]  out_idx;
  logic               done;

  conv_relu_pool dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .c_in      (c_in),
    .bias      (bias),
    .shift     (shift),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Tile under test, plus an alternate tile used for the ignored start
  logic signed [15:0] tile_a [0:3][0:3];
  logic signed [15:0] tile_b [0:3][0:3];
  logic signed [15:0] bias_a;
  logic        [3:0]  shift_a;
  int                 exp_p [4];

  // Collected results of one run
  int got_data [$];
  int got_idx  [$];
  int got_cyc  [$];
  int hold_data[$];
  int hold_idx [$];
  int done_cyc;
  int first_valid;
  int stall_idx;
  int stall_len;
  int ign_at;

  // Reference: quantise each element with integer arithmetic, then 2x2 max
  function automatic void model();
    int q [4][4];
    int s;
    int sh;
    sh = int'(shift_a);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = int'(tile_a[r][c]) + int'(bias_a);
        if (s < 0) s = 0;
        if (sh != 0) s = (s + (1 << (sh - 1))) >> sh;
        if (s > 127) s = 127;
        q[r][c] = s;
      end
    end
    for (int w = 0; w < 4; w++) begin
      int m;
      m = 0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          if (q[2*(w/2)+dr][2*(w%2)+dc] > m) m = q[2*(w/2)+dr][2*(w%2)+dc];
        end
      end
      exp_p[w] = m;
    end
  endfunction

  function automatic void fill_const(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tile_a[r][c] = 16'(v);
  endfunction

  function automatic void fill_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tile_a[r][c] = 16'(4*r + c);
  endfunction

  function automatic void fill_random();
    int mode;
    mode = int'($urandom_range(0, 2));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mode == 0) tile_a[r][c] = 16'($urandom);
        else           tile_a[r][c] = 16'(int'($urandom_range(0, 1000)) - 300);
      end
    end
    bias_a  = (mode == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 200)) - 100);
    shift_a = 4'($urandom_range(0, 15));
    if (mode == 1) shift_a = 4'($urandom_range(0, 3));
  endfunction

  // Stimulus driver: start tile_a at the next edge, then record every
  // accepted output, stalled samples and the done cycle (cycle 0 = start edge)
  task automatic collect();
    int stalls;
    stalls = 0;
    got_data.delete(); got_idx.delete(); got_cyc.delete();
    hold_data.delete(); hold_idx.delete();
    done_cyc = -1;
    first_valid = -1;
    c_in  = tile_a;
    bias  = bias_a;
    shift = shift_a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      if (t == ign_at) begin
        c_in  = tile_b;
        bias  = 16'($urandom);
        shift = 4'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (out_valid && first_valid < 0) first_valid = t;
      if (out_valid && int'(out_idx) == stall_idx && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
        hold_data.push_back(int'(out_data));
        hold_idx.push_back(int'(out_idx));
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_idx.push_back(int'(out_idx));
        got_cyc.push_back(t);
      end
      if (done) begin
        done_cyc = t;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    stall_idx = -1;
    stall_len = 0;
    ign_at = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          c_in[r][c] = 16'($urandom);
      bias  = 16'($urandom);
      shift = 4'($urandom);
      start = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({busy, out_valid, done, out_data, out_idx} !== 13'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: busy=%b valid=%b done=%b data=%0d idx=%0d, required all 0",
                 i, busy, out_valid, done, out_data, out_idx);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pool_order();
    fill_ramp();
    bias_a = 16'd0;
    shift_a = 4'd0;
    collect();
    checks++;
    if (got_data.size() != 4 || first_valid != 21) begin
      errors++;
      $display("FAIL pool_order count/first_valid: got %0d outputs first at %0d, required 4 at 21",
               got_data.size(), first_valid);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] != 5 + 2*(i%2) + 8*(i/2) || got_idx[i] != i || got_cyc[i] != 21 + i) begin
          errors++;
          $display("FAIL pool_order out %0d: data=%0d idx=%0d cyc=%0d, required data=%0d idx=%0d cyc=%0d",
                   i, got_data[i], got_idx[i], got_cyc[i], 5 + 2*(i%2) + 8*(i/2), i, 21 + i);
        end
      end
    end
    checks++;
    if (done_cyc != 25 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pool_order done: done_cyc=%0d busy=%b valid=%b, required 25/0/0",
               done_cyc, busy, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL pool_order done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_relu_sat_round();
    int cval [4];
    int bval [4];
    int sval [4];
    int want [4];
    cval = '{-500, 32767, 5, 200};
    bval = '{0, 32767, 0, -100};
    sval = '{0, 0, 1, 2};
    want = '{0, 127, 3, 25};
    for (int n = 0; n < 4; n++) begin
      fill_const(cval[n]);
      bias_a  = 16'(bval[n]);
      shift_a = 4'(sval[n]);
      collect();
      checks++;
      if (got_data.size() != 4 || done_cyc != 25) begin
        errors++;
        $display("FAIL relu_sat_round case %0d: %0d outputs done at %0d, required 4 at 25",
                 n, got_data.size(), done_cyc);
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (got_data[i] != want[n] || got_idx[i] != i) begin
            errors++;
            $display("FAIL relu_sat_round case %0d out %0d: data=%0d idx=%0d, required %0d idx %0d",
                     n, i, got_data[i], got_idx[i], want[n], i);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    bias_a = 16'd0;
    shift_a = 4'd0;
    stall_idx = 1;
    stall_len = 3;
    collect();
    checks++;
    if (hold_data.size() != 3) begin
      errors++;
      $display("FAIL backpressure stalls: %0d stalled cycles, required 3", hold_data.size());
    end
    for (int i = 0; i < hold_data.size(); i++) begin
      checks++;
      if (hold_data[i] != 7 || hold_idx[i] != 1) begin
        errors++;
        $display("FAIL backpressure hold %0d: data=%0d idx=%0d, required 7 idx 1",
                 i, hold_data[i], hold_idx[i]);
      end
    end
    checks++;
    if (got_data.size() != 4 || done_cyc != 28) begin
      errors++;
      $display("FAIL backpressure done: %0d outputs done at %0d, required 4 at 28",
               got_data.size(), done_cyc);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] != 5 + 2*(i%2) + 8*(i/2) || got_idx[i] != i) begin
          errors++;
          $display("FAIL backpressure out %0d: data=%0d idx=%0d, required %0d idx %0d",
                   i, got_data[i], got_idx[i], 5 + 2*(i%2) + 8*(i/2), i);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tile_b[r][c] = 16'(int'($urandom_range(0, 20000)) - 10000);
    model();
    ign_at = 10;
    collect();
    checks++;
    if (got_data.size() != 4 || done_cyc != 25) begin
      errors++;
      $display("FAIL ignored_start: %0d outputs done at %0d, required 4 at 25",
               got_data.size(), done_cyc);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] != exp_p[i] || got_idx[i] != i) begin
          errors++;
          $display("FAIL ignored_start out %0d: data=%0d idx=%0d, required %0d idx %0d",
                   i, got_data[i], got_idx[i], exp_p[i], i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    bias_a = 16'd0;
    shift_a = 4'd0;
    collect();
    checks++;
    if (done_cyc != 25) begin
      errors++;
      $display("FAIL back_to_back first done: cycle %0d, required 25", done_cyc);
    end
    // Start again in the done cycle
    fill_random();
    model();
    collect();
    checks++;
    if (first_valid != 21 || got_data.size() != 4 || done_cyc != 25) begin
      errors++;
      $display("FAIL back_to_back second: first_valid=%0d outputs=%0d done=%0d, required 21/4/25",
               first_valid, got_data.size(), done_cyc);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] != exp_p[i] || got_idx[i] != i) begin
          errors++;
          $display("FAIL back_to_back out %0d: data=%0d idx=%0d, required %0d idx %0d",
                   i, got_data[i], got_idx[i], exp_p[i], i);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bit found;
      fill_random();
      c_in = tile_a; bias = bias_a; shift = shift_a;
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int t = 1; t <= 60; t++) begin
        if (pass == 0 && t == 8) begin found = 1'b1; break; end
        if (pass == 1 && out_valid && out_idx == 2'd2) begin found = 1'b1; break; end
        @(posedge clk); #1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL mid_reset pass %0d: reset point never reached", pass);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, out_valid, done, out_data, out_idx} !== 13'd0) begin
        errors++;
        $display("FAIL mid_reset pass %0d immediate: busy=%b valid=%b done=%b data=%0d idx=%0d, required 0",
                 pass, busy, out_valid, done, out_data, out_idx);
      end
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (i == 2) rst_n = 1'b1;
      end
      for (int i = 0; i < 30; i++) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset pass %0d after release cycle %0d: done=%b busy=%b, required 0",
                   pass, i, done, busy);
        end
        @(posedge clk); #1;
      end
      fill_random();
      model();
      collect();
      checks++;
      if (got_data.size() != 4 || done_cyc != 25) begin
        errors++;
        $display("FAIL mid_reset pass %0d rerun: %0d outputs done at %0d, required 4 at 25",
                 pass, got_data.size(), done_cyc);
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (got_data[i] != exp_p[i] || got_idx[i] != i) begin
            errors++;
            $display("FAIL mid_reset pass %0d out %0d: data=%0d idx=%0d, required %0d idx %0d",
                     pass, i, got_data[i], got_idx[i], exp_p[i], i);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      fill_random();
      model();
      stall_idx = int'($urandom_range(0, 3));
      stall_len = int'($urandom_range(0, 3));
      begin
        int want_done;
        want_done = 25 + stall_len;
        collect();
        checks++;
        if (got_data.size() != 4 || done_cyc != want_done) begin
          errors++;
          $display("FAIL random %0d: %0d outputs done at %0d, required 4 at %0d",
                   n, got_data.size(), done_cyc, want_done);
        end else begin
          for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] != exp_p[i] || got_idx[i] != i) begin
              errors++;
              $display("FAIL random %0d out %0d: data=%0d idx=%0d, required %0d idx %0d",
                       n, i, got_data[i], got_idx[i], exp_p[i], i);
            end
          end
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    bias = '0;
    shift = '0;
    stall_idx = -1;
    stall_len = 0;
    ign_at = -1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        c_in[r][c] = '0;
    #2;
    test_reset();
    test_pool_order();
    test_relu_sat_round();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
